// File: rtl/threadbrain_pkg.sv
// Shared threadbrain definitions: instruction width, opcode encodings and the
// default instruction address width. The fetch stage and the ALU both import
// this package so the two agree on what a NOP and a HALT look like.
package threadbrain_pkg;

  localparam int INS_W      = 16;
  localparam int ADDR_W_DEF = 12;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_PLUS  = 4'h1;
  localparam logic [3:0] OP_MINUS = 4'h2;
  localparam logic [3:0] OP_INC   = 4'h3;
  localparam logic [3:0] OP_DEC   = 4'h4;
  localparam logic [3:0] OP_BRZ   = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Bubble inserted whenever no real instruction is presented to the ALU.
  localparam logic [INS_W-1:0] NOP_INS = 16'h0000;

  function automatic logic [3:0] opcode_of(input logic [INS_W-1:0] ins);
    return ins[INS_W-1:INS_W-4];
  endfunction

endpackage

// File: rtl/bf_fetch.sv
// Instruction fetch stage feeding the ALU. One synchronous imem read per
// cycle, two-cycle branch penalty with same-cycle squash of the instruction
// behind the branch, and a short drain window after HALT during which an
// older branch can still pull the core back into RUN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | fetching sequentially, one read per cycle
// ST_DRAIN  | HALT captured; waiting two cycles for a cancelling branch
// ST_HALTED | fetch stopped until reset; branches ignored
module bf_fetch
  import threadbrain_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [INS_W-1:0]  imem_rdata,
  input  logic              branch_en,
  input  logic [INS_W-1:0]  branch_val,
  output logic [INS_W-1:0]  ins_out,
  output logic              ins_valid,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              halted
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] rd_pc_q, rd_pc_d;
  logic [INS_W-1:0]  ins_q, ins_d;
  logic              ins_v_q, ins_v_d;
  logic [ADDR_W-1:0] ins_pc_q, ins_pc_d;
  logic [1:0]        state_q, state_d;
  logic [1:0]        drain_cnt_q, drain_cnt_d;
  logic              halted_q, halted_d;

  logic              branch_live;
  logic              issue;
  logic              capture;
  logic              halt_seen;
  logic              branch_val_unused;

  // Only the low ADDR_W bits of the redirect target form an address.
  assign branch_val_unused = ^branch_val[INS_W-1:ADDR_W];

  // Read issue, capture qualification and HALT detection.
  always_comb begin
    branch_live = branch_en & (state_q != ST_HALTED);
    issue       = (state_q == ST_RUN) | ((state_q == ST_DRAIN) & branch_live);
    imem_addr   = branch_live ? branch_val[ADDR_W-1:0] : pc_q;
    // Reads returning in DRAIN were issued behind the HALT and are dropped.
    capture     = rd_pend_q & ~branch_live & (state_q == ST_RUN);
    halt_seen   = capture & (opcode_of(imem_rdata) == OP_HALT);
  end

  // Next-state for the PC, read tracking and the ALU-facing instruction.
  always_comb begin
    pc_d      = pc_q;
    rd_pend_d = issue;
    rd_pc_d   = rd_pc_q;
    ins_d     = NOP_INS;
    ins_v_d   = 1'b0;
    ins_pc_d  = ins_pc_q;
    if (issue) begin
      pc_d    = imem_addr + ADDR_W'(1);
      rd_pc_d = imem_addr;
    end
    if (capture) begin
      ins_d    = imem_rdata;
      ins_v_d  = 1'b1;
      ins_pc_d = rd_pc_q;
    end
  end

  // RUN / DRAIN / HALTED sequencing with the drain down-counter.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    halted_d    = halted_q;
    case (state_q)
      ST_RUN: begin
        if (halt_seen) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 2'd2;
        end
      end
      ST_DRAIN: begin
        if (branch_live) begin
          state_d = ST_RUN;
        end else begin
          drain_cnt_d = drain_cnt_q - 2'd1;
          if (drain_cnt_q == 2'd1) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers; reset drops any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      rd_pend_q   <= 1'b0;
      rd_pc_q     <= '0;
      ins_q       <= NOP_INS;
      ins_v_q     <= 1'b0;
      ins_pc_q    <= '0;
      state_q     <= ST_RUN;
      drain_cnt_q <= 2'd0;
      halted_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rd_pend_q   <= rd_pend_d;
      rd_pc_q     <= rd_pc_d;
      ins_q       <= ins_d;
      ins_v_q     <= ins_v_d;
      ins_pc_q    <= ins_pc_d;
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
    end
  end

  // A redirect this cycle kills whatever sits behind the branch.
  always_comb begin
    imem_en   = issue;
    ins_out   = branch_live ? NOP_INS : ins_q;
    ins_valid = ins_v_q & ~branch_live;
    ins_pc    = ins_pc_q;
    halted    = halted_q;
  end

endmodule

// File: tb/tb_bf_fetch.sv
// Directed bench for bf_fetch: straight-line fetch, branch squash, back-to-back
// branches, HALT drain, HALT cancel, async reset while halted, and PC wrap on a
// second instance started at 0xFFE.
module tb_bf_fetch;
  import threadbrain_pkg::*;

  logic        clk;
  logic        rst_n;

  logic [11:0] imem_addr;
  logic        imem_en;
  logic [15:0] imem_rdata;
  logic        br_en;
  logic [15:0] br_val;
  logic [15:0] ins_out;
  logic        ins_valid;
  logic [11:0] ins_pc;
  logic        halted;

  logic [11:0] w_addr;
  logic        w_en;
  logic [15:0] w_rdata;
  logic        w_br_en;
  logic [15:0] w_br_val;
  logic [15:0] w_ins_out;
  logic        w_ins_valid;
  logic [11:0] w_ins_pc;
  logic        w_halted;

  logic [15:0] mem   [0:4095];
  logic [15:0] mem_w [0:4095];

  int n_chk;
  int n_pass;

  bf_fetch #(.ADDR_W(12), .RESET_PC(12'h000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .branch_en(br_en), .branch_val(br_val),
    .ins_out(ins_out), .ins_valid(ins_valid), .ins_pc(ins_pc), .halted(halted)
  );

  bf_fetch #(.ADDR_W(12), .RESET_PC(12'hFFE)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(w_addr), .imem_en(w_en), .imem_rdata(w_rdata),
    .branch_en(w_br_en), .branch_val(w_br_val),
    .ins_out(w_ins_out), .ins_valid(w_ins_valid), .ins_pc(w_ins_pc), .halted(w_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memories, one cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
    if (w_en)    w_rdata    <= mem_w[w_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]   = 16'h0000;
      mem_w[i] = 16'h0000;
    end
    mem[12'h000] = 16'h1000;
    mem[12'h001] = 16'h3000;
    mem[12'h002] = 16'h2000;
    mem[12'h003] = 16'hF000;
    mem[12'h010] = 16'h1234;
    mem[12'h011] = 16'h2001;
    mem[12'h040] = 16'h3777;
    mem[12'h041] = 16'h4123;
    mem[12'h080] = 16'h2ABC;
    mem_w[12'hFFE] = 16'h1111;
    mem_w[12'hFFF] = 16'h2222;
    mem_w[12'h000] = 16'h3333;

    rst_n = 1'b0; br_en = 1'b0; br_val = 16'h0000;
    w_br_en = 1'b0; w_br_val = 16'h0000;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ins_out", ins_out, 16'h0000);
    chk("rst_ins_valid", ins_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_addr", imem_addr, 12'h000);

    // Straight-line fetch, cycle 0 begins at release
    rst_n = 1'b1;
    #1;
    chk("c0_en", imem_en, 1'b1);
    chk("c0_addr", imem_addr, 12'h000);
    chk("w_c0_addr", w_addr, 12'hFFE);
    tick();
    chk("c1_addr", imem_addr, 12'h001);
    chk("c1_valid", ins_valid, 1'b0);
    chk("w_c1_addr", w_addr, 12'hFFF);
    tick();
    chk("c2_addr", imem_addr, 12'h002);
    chk("c2_ins", ins_out, 16'h1000);
    chk("c2_valid", ins_valid, 1'b1);
    chk("c2_pc", ins_pc, 12'h000);
    chk("w_c2_addr", w_addr, 12'h000);
    chk("w_c2_ins", w_ins_out, 16'h1111);
    chk("w_c2_pc", w_ins_pc, 12'hFFE);
    tick();
    chk("c3_ins", ins_out, 16'h3000);
    chk("c3_pc", ins_pc, 12'h001);
    chk("w_c3_ins", w_ins_out, 16'h2222);
    chk("w_c3_pc", w_ins_pc, 12'hFFF);
    tick();
    chk("c4_ins", ins_out, 16'h2000);
    chk("c4_en", imem_en, 1'b1);
    chk("w_c4_ins", w_ins_out, 16'h3333);
    chk("w_c4_pc", w_ins_pc, 12'h000);

    // HALT returned in cycle 4
    tick();
    chk("h1_ins", ins_out, 16'hF000);
    chk("h1_valid", ins_valid, 1'b1);
    chk("h1_pc", ins_pc, 12'h003);
    chk("h1_en", imem_en, 1'b0);
    chk("h1_halted", halted, 1'b0);
    tick();
    chk("h2_en", imem_en, 1'b0);
    chk("h2_ins", ins_out, 16'h0000);
    chk("h2_valid", ins_valid, 1'b0);
    chk("h2_halted", halted, 1'b0);
    tick();
    chk("h3_halted", halted, 1'b1);
    chk("h3_ins", ins_out, 16'h0000);
    chk("h3_en", imem_en, 1'b0);

    // Branch ignored once halted, then async reset with the branch held
    tick();
    br_en = 1'b1; br_val = 16'h0040;
    #1;
    chk("hb_en", imem_en, 1'b0);
    chk("hb_ins", ins_out, 16'h0000);
    chk("hb_halted", halted, 1'b1);
    tick();
    chk("hb2_halted", halted, 1'b1);
    chk("hb2_valid", ins_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("ar_halted", halted, 1'b0);
    chk("ar_ins", ins_out, 16'h0000);
    chk("ar_valid", ins_valid, 1'b0);
    br_en = 1'b0;
    #1;
    chk("ar_addr", imem_addr, 12'h000);
    chk("ar_en", imem_en, 1'b1);

    // Restart from RESET_PC, branch in cycle 2
    tick();
    rst_n = 1'b1;
    #1;
    chk("r0_addr", imem_addr, 12'h000);
    tick();
    chk("r1_addr", imem_addr, 12'h001);
    tick();
    br_en = 1'b1; br_val = 16'h0040;
    #1;
    chk("b0_addr", imem_addr, 12'h040);
    chk("b0_en", imem_en, 1'b1);
    chk("b0_ins", ins_out, 16'h0000);
    chk("b0_valid", ins_valid, 1'b0);
    tick();
    br_en = 1'b0;
    #1;
    chk("b1_ins", ins_out, 16'h0000);
    chk("b1_valid", ins_valid, 1'b0);
    chk("b1_addr", imem_addr, 12'h041);
    tick();
    chk("b2_ins", ins_out, 16'h3777);
    chk("b2_valid", ins_valid, 1'b1);
    chk("b2_pc", ins_pc, 12'h040);

    // Back-to-back branches: 0x080 then 0x040
    tick();
    br_en = 1'b1; br_val = 16'h0080;
    #1;
    chk("bb0_addr", imem_addr, 12'h080);
    chk("bb0_ins", ins_out, 16'h0000);
    tick();
    br_val = 16'h0040;
    #1;
    chk("bb1_addr", imem_addr, 12'h040);
    chk("bb1_ins", ins_out, 16'h0000);
    tick();
    br_en = 1'b0;
    #1;
    chk("bb2_ins", ins_out, 16'h0000);
    chk("bb2_valid", ins_valid, 1'b0);
    tick();
    chk("bb3_ins", ins_out, 16'h3777);
    chk("bb3_pc", ins_pc, 12'h040);
    tick();
    chk("bb4_ins", ins_out, 16'h4123);
    chk("bb4_pc", ins_pc, 12'h041);

    // Halt cancelled by a branch in the second drain cycle
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("hc_ins", ins_out, 16'hF000);
    tick();
    br_en = 1'b1; br_val = 16'h0010;
    #1;
    chk("hc0_en", imem_en, 1'b1);
    chk("hc0_addr", imem_addr, 12'h010);
    chk("hc0_ins", ins_out, 16'h0000);
    tick();
    br_en = 1'b0;
    #1;
    chk("hc1_halted", halted, 1'b0);
    chk("hc1_en", imem_en, 1'b1);
    chk("hc1_addr", imem_addr, 12'h011);
    tick();
    chk("hc2_ins", ins_out, 16'h1234);
    chk("hc2_valid", ins_valid, 1'b1);
    chk("hc2_pc", ins_pc, 12'h010);
    chk("hc2_halted", halted, 1'b0);
    tick();
    chk("hc3_ins", ins_out, 16'h2001);
    chk("hc3_halted", halted, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bf_fetch.md
# bf_fetch

Instruction fetch stage of the threadbrain core, directly upstream of the ALU stage. Reads one 16-bit instruction per cycle from a synchronous instruction memory and drives it to the ALU's `ins_in`. Accepts the ALU's `branch_en`/`branch_val` redirect, squashing wrong-path instructions as NOPs. Stops fetching once a HALT instruction retires.

## Interface
- `ADDR_W`, 12: instruction address width; matches the 12-bit BRZ target field.
- `RESET_PC`, 0: first fetch address after reset.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `imem_addr` out ADDR_W: instruction memory read address.
- `imem_en` out 1: read strobe; data is returned on `imem_rdata` the following cycle.
- `imem_rdata` in 16: read data.
- `branch_en` in 1: redirect request from the ALU (combinational on the ALU side).
- `branch_val` in 16: redirect target; only `[ADDR_W-1:0]` is used.
- `ins_out` out 16: instruction to the ALU `ins_in`.
- `ins_valid` out 1: `ins_out` is a real (non-bubble) instruction.
- `ins_pc` out ADDR_W: address of `ins_out`; debug only.
- `halted` out 1: fetch has permanently stopped.

## Operation
- Opcodes `[15:12]`: NOP 0, PLUS 1, MINUS 2, INC 3, DEC 4, BRZ 5, HALT F. The bubble value is `16'h0000`.
- **State registers:**
  - `pc`: next sequential address.
  - `rd_pend`, `rd_pc`: a read issued last cycle.
  - `ins_q`, `ins_v`, `ins_pc_q`: instruction presented to the ALU.
  - `state`: RUN / DRAIN / HALTED.
  - `drain_cnt`: 2 bits.
- **Read issue:**
  - `imem_en` = (state==RUN) | (state==DRAIN & branch_en).
  - `imem_addr` = branch_en ? `branch_val[ADDR_W-1:0]` : `pc`.
  - On issue: `pc <= imem_addr+1`, wrapping modulo 2^ADDR_W; `rd_pend <= 1`; `rd_pc <= imem_addr`.
  - With no issue: `rd_pend <= 0`.
- **Capture:**
  - If `rd_pend & ~branch_en`: `ins_q <= imem_rdata`, `ins_v <= 1`, `ins_pc_q <= rd_pc`.
  - If `branch_en`: `ins_q <= NOP`, `ins_v <= 0` (squashes the wrong-path read data).
  - Otherwise: `ins_q <= NOP`, `ins_v <= 0`.
- **Output:**
  - `ins_out` = branch_en ? NOP : `ins_q`.
  - `ins_valid` = `ins_v & ~branch_en`.
  - This squashes, in the same cycle, the instruction that follows the branch.
- **HALT detection:** on RUN with `rd_pend & ~branch_en & imem_rdata[15:12]==F` → DRAIN, `drain_cnt <= 2`. The read issued that same cycle is discarded (no capture in DRAIN unless redirected).
- **DRAIN:**
  - `branch_en` → RUN, issuing the target read that cycle. An older branch squashes the HALT.
  - Otherwise `drain_cnt` decrements; at 1 → HALTED with `halted <= 1`.
- **HALTED:** terminal until reset. `imem_en`=0, `ins_out`=NOP, `branch_en` ignored.
- HALT is presented to the ALU as an ordinary instruction; the ALU treats it as a no-op.

## Timing
- **Reset values:**
  - `pc`=RESET_PC, `rd_pend`=0, `ins_q`=NOP, `ins_v`=0, `ins_pc_q`=0.
  - `state`=RUN, `halted`=0, so `ins_out`=0000 and `ins_valid`=0.
  - First read of RESET_PC is issued in the first cycle after reset release.
- **Fetch latency:** address issued in cycle c → rdata in c+1 → on `ins_out` in c+2. Throughput is 1 instruction/cycle.
- **Branch asserted in cycle b:**
  - Target read issued in cycle b.
  - `ins_out`=NOP in b and b+1.
  - Target instruction on `ins_out` in b+2 (2-cycle penalty).
- **Back-to-back branches:** each `branch_en` cycle restarts the sequence from its own target.
- **HALT on `imem_rdata` in cycle h:**
  - HALT is on `ins_out` in h+1.
  - `halted`=1 from h+3.
  - A `branch_en` in h+1 or h+2 cancels the halt.
- **Reset mid-operation:** asynchronous. All registers take their reset values immediately; in-flight reads are dropped.

## Structure
- Shared package `threadbrain_pkg`: opcode constants (NOP/PLUS/MINUS/INC/DEC/BRZ/HALT), `INS_W`=16, the NOP encoding, and the default ADDR_W. The ALU must use the same constants.
- Single module; the three-state FSM and the datapath are small enough that no sub-module is warranted.

## Test plan
- **Reset and straight-line fetch:** reset release with memory {0:1000,1:3000,2:2000} → `imem_addr` 0,1,2 on consecutive cycles; `ins_out` 1000,3000,2000 from cycle 2; `ins_pc` 0,1,2.
- **Branch squash:** `branch_en`=1 with `branch_val`=0x040 in cycle b → `ins_out`=0000 with `ins_valid`=0 in b and b+1; `imem_addr`=040 in b; instruction at 0x040 on `ins_out` in b+2.
- **PC wrap:** RESET_PC=0xFFE → fetches 0xFFE, 0xFFF, 0x000 in order.
- **Halt:** HALT at address 3 with no branches → `imem_en` low after the cycle HALT returns; `halted`=1 three cycles after HALT appears on `imem_rdata`; `ins_out` stays 0000 thereafter.
- **Halt cancelled:** `branch_en` (target 0x010) asserted the cycle after HALT reaches `ins_out` → state returns to RUN, 0x010 is fetched, and `halted` stays 0.
- **Async reset mid-stream:** `rst_n` low mid-cycle during a branch → `ins_out`=0000 and `halted`=0 immediately; fetch restarts at RESET_PC.
